// File: rtl/instr_receiver_pkg.sv
// Shared definitions for the MBED instruction link: receiver state codes and
// instruction field positions, also used by the servo-control FSM.
package instr_receiver_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_ACK    = 2'd2,
        ST_DONE   = 2'd3
    } rx_state_t;

    localparam int MODE_MSB = 9;
    localparam int MODE_LSB = 8;
    localparam int POS_MSB  = 7;
    localparam int POS_LSB  = 0;

endpackage

// File: rtl/instr_receiver_sync.sv
// Multi-stage flip-flop synchroniser for one asynchronous input bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: clocked state uses non-blocking assignments so every stage samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/instr_receiver.sv
// Serial MSB-first instruction receiver with a four-phase per-bit handshake,
// mid-frame stall timeout and a one-cycle instruction_ready strobe.
module instr_receiver
    import instr_receiver_pkg::*;
#(
    parameter int WIDTH          = 10,
    parameter int TIMEOUT_CYCLES = 2400000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_ready,
    input  logic             data_bit,
    output logic             data_ack,
    output logic [WIDTH-1:0] instruction,
    output logic             instruction_ready,
    output logic             frame_error,
    output logic [3:0]       bit_count,
    output logic [1:0]       state
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic ready_s, bit_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ready (
        .clk   (clk),
        .reset (reset),
        .d_i   (data_ready),
        .q_o   (ready_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_bit (
        .clk   (clk),
        .reset (reset),
        .d_i   (data_bit),
        .q_o   (bit_s)
    );

    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             ack_q, ack_d;
    logic             irdy_q, irdy_d;
    logic             ferr_q, ferr_d;
    logic             active;
    logic [3:0]       cnt_inc;

    assign cnt_inc = cnt_q + 4'd1;
    assign active  = (cnt_q != 4'd0) || (state_q == ST_SAMPLE) || (state_q == ST_ACK);

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        ack_d   = ack_q;
        irdy_d  = 1'b0;
        ferr_d  = 1'b0;
        tmo_d   = '0;

        case (state_q)
            ST_WAIT: begin
                if (ready_s) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                shreg_d = {shreg_q[WIDTH-2:0], bit_s};
                ack_d   = 1'b1;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (!ready_s) begin
                    ack_d   = 1'b0;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == 4'(WIDTH)) ? ST_DONE : ST_WAIT;
                end
            end
            ST_DONE: begin
                instr_d = shreg_q;
                irdy_d  = 1'b1;
                cnt_d   = 4'd0;
                state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase

        // The stall timer measures time spent in a single state of a live frame.
        if (state_d == state_q && active) tmo_d = tmo_q + TW'(1);

        if (active && tmo_q == TMO_LAST) begin
            state_d = ST_WAIT;
            shreg_d = '0;
            instr_d = instr_q;
            cnt_d   = 4'd0;
            ack_d   = 1'b0;
            irdy_d  = 1'b0;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT;
            shreg_q <= '0;
            instr_q <= '0;
            cnt_q   <= 4'd0;
            tmo_q   <= '0;
            ack_q   <= 1'b0;
            irdy_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            ack_q   <= ack_d;
            irdy_q  <= irdy_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_ack          = ack_q;
    assign instruction       = instr_q;
    assign instruction_ready = irdy_q;
    assign frame_error       = ferr_q;
    assign bit_count         = cnt_q;
    assign state             = state_q;

endmodule

// File: tb/tb_instr_receiver.sv
// Scoreboard bench for instr_receiver: stimulus pushes expected instructions
// and timeout events; a monitor pops and compares on every strobe.
module tb_instr_receiver;
    import instr_receiver_pkg::*;

    localparam int TMO      = 50;
    localparam int TMO_LONG = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_ready, data_bit;
    logic       data_ack, instruction_ready, frame_error;
    logic [9:0] instruction;
    logic [3:0] bit_count;
    logic [1:0] state;

    logic       ready2, bit2;
    logic       ack2, ir2, fe2;
    logic [9:0] instr2;
    logic [3:0] bc2;
    logic [1:0] st2;

    always #5 clk = ~clk;

    instr_receiver #(.WIDTH(10), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) u_dut (
        .clk               (clk),
        .reset             (reset),
        .data_ready        (data_ready),
        .data_bit          (data_bit),
        .data_ack          (data_ack),
        .instruction       (instruction),
        .instruction_ready (instruction_ready),
        .frame_error       (frame_error),
        .bit_count         (bit_count),
        .state             (state)
    );

    // Long-timeout instance used only for the held-high single-bit case.
    instr_receiver #(.WIDTH(10), .TIMEOUT_CYCLES(TMO_LONG), .SYNC_STAGES(2)) u_dut_long (
        .clk               (clk),
        .reset             (reset),
        .data_ready        (ready2),
        .data_bit          (bit2),
        .data_ack          (ack2),
        .instruction       (instr2),
        .instruction_ready (ir2),
        .frame_error       (fe2),
        .bit_count         (bc2),
        .state             (st2)
    );

    int checks   = 0;
    int failures = 0;
    int ack_rises = 0;

    logic [9:0] exp_instr_q[$];
    bit         exp_err_q[$];
    logic       prev_ir, prev_fe, prev_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_ir  <= 1'b0;
            prev_fe  <= 1'b0;
            prev_ack <= 1'b0;
        end else begin
            if (instruction_ready) begin
                if (exp_instr_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
                else check("instruction", 32'(instruction), 32'(exp_instr_q.pop_front()));
                check("strobe_width", 32'(prev_ir), 32'd0);
            end
            if (frame_error) begin
                if (exp_err_q.size() == 0) check("unexpected_frame_error", 32'd1, 32'd0);
                else void'(exp_err_q.pop_front());
                check("frame_error_width", 32'(prev_fe), 32'd0);
            end
            if (data_ack && !prev_ack) ack_rises++;
            prev_ir  <= instruction_ready;
            prev_fe  <= frame_error;
            prev_ack <= data_ack;
        end
    end

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (data_ack !== lvl && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (data_ack !== lvl) check(name, 32'(data_ack), 32'(lvl));
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        data_bit = b;
        @(negedge clk);
        data_ready = 1'b1;
        wait_ack(1'b1, "ack_rise_timeout");
        data_ready = 1'b0;
        wait_ack(1'b0, "ack_fall_timeout");
    endtask

    task automatic send_frame(input logic [9:0] v, input bit expect_it);
        if (expect_it) exp_instr_q.push_back(v);
        for (int i = 9; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_instruction"}, 32'(instruction), 32'd0);
        check({tag, "_instr_ready"}, 32'(instruction_ready), 32'd0);
        check({tag, "_frame_error"}, 32'(frame_error), 32'd0);
        check({tag, "_data_ack"}, 32'(data_ack), 32'd0);
        check({tag, "_bit_count"}, 32'(bit_count), 32'd0);
        check({tag, "_state"}, 32'(state), 32'(ST_WAIT));
    endtask

    initial begin
        int a0, bad_ack, bad_bc, bad_fe, bad_idle;
        reset = 1'b1;
        data_ready = 1'b0;
        data_bit = 1'b0;
        ready2 = 1'b0;
        bit2 = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // Single well-behaved frame.
        a0 = ack_rises;
        send_frame(10'h2A5, 1'b1);
        repeat (3) @(negedge clk);
        check("f1_pending", 32'(exp_instr_q.size()), 32'd0);
        check("f1_ack_pulses", 32'(ack_rises - a0), 32'd10);
        check("f1_bit_count", 32'(bit_count), 32'd0);
        check("f1_state", 32'(state), 32'(ST_WAIT));
        check("f1_instruction", 32'(instruction), 32'h2A5);

        // Back-to-back frames; the first value must hold mid-way through the second.
        send_frame(10'h3FF, 1'b1);
        exp_instr_q.push_back(10'h100);
        for (int i = 9; i >= 5; i--) send_bit(1'(10'h100 >> i));
        check("b2b_first_seen", 32'(exp_instr_q.size()), 32'd1);
        check("b2b_hold", 32'(instruction), 32'h3FF);
        for (int i = 4; i >= 0; i--) send_bit(1'(10'h100 >> i));
        repeat (3) @(negedge clk);
        check("b2b_pending", 32'(exp_instr_q.size()), 32'd0);
        check("b2b_instruction", 32'(instruction), 32'h100);

        // Partial frame stalls and must be aborted.
        exp_err_q.push_back(1'b1);
        for (int i = 9; i >= 6; i--) send_bit(1'(10'h0AB >> i));
        check("tmo_bit_count_mid", 32'(bit_count), 32'd4);
        repeat (TMO + 20) @(negedge clk);
        check("tmo_error_seen", 32'(exp_err_q.size()), 32'd0);
        check("tmo_bit_count", 32'(bit_count), 32'd0);
        check("tmo_state", 32'(state), 32'(ST_WAIT));
        check("tmo_instr_kept", 32'(instruction), 32'h100);
        send_frame(10'h155, 1'b1);
        repeat (3) @(negedge clk);
        check("tmo_next_pending", 32'(exp_instr_q.size()), 32'd0);
        check("tmo_next_instr", 32'(instruction), 32'h155);

        // data_ready held high for 1000 cycles on one bit.
        bit2 = 1'b1;
        @(negedge clk);
        ready2 = 1'b1;
        repeat (6) @(negedge clk);
        bad_ack = 0; bad_bc = 0; bad_fe = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ack2 !== 1'b1 || st2 !== 2'(ST_ACK)) bad_ack++;
            if (bc2 !== 4'd0) bad_bc++;
            if (fe2 !== 1'b0 || ir2 !== 1'b0) bad_fe++;
        end
        check("hold_ack_low_cycles", 32'(bad_ack), 32'd0);
        check("hold_bit_count_moves", 32'(bad_bc), 32'd0);
        check("hold_strobes", 32'(bad_fe), 32'd0);
        ready2 = 1'b0;
        repeat (6) @(negedge clk);
        check("hold_release_ack", 32'(ack2), 32'd0);
        check("hold_release_bc", 32'(bc2), 32'd1);
        check("hold_instr2", 32'(instr2), 32'd0);

        // Asynchronous reset during bit 7.
        for (int i = 9; i >= 3; i--) send_bit(1'(10'h3C3 >> i));
        check("rst_bc_before", 32'(bit_count), 32'd7);
        @(negedge clk);
        data_bit = 1'b0;
        @(negedge clk);
        data_ready = 1'b1;
        wait_ack(1'b1, "rst_ack_rise_timeout");
        #2;
        reset = 1'b1;
        data_ready = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_frame(10'h0FF, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_next_pending", 32'(exp_instr_q.size()), 32'd0);
        check("rst_next_instr", 32'(instruction), 32'h0FF);

        // Long idle gap with no frame in progress.
        bad_idle = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (state !== 2'(ST_WAIT) || frame_error !== 1'b0) bad_idle++;
        end
        check("idle_violations", 32'(bad_idle), 32'd0);
        check("final_err_pending", 32'(exp_err_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
